// File: rtl/reram_bridge_pkg.sv
// Shared types and constants for the ReRAM Wishbone bridge.
// Holds the FSM state encoding, CSR offsets and error return patterns.
package reram_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam logic [15:0] CsrStatus  = 16'h8000;
  localparam logic [15:0] CsrCtrl    = 16'h8004;
  localparam logic [15:0] CsrTimeout = 16'h8008;
  localparam logic [15:0] CsrTxcnt   = 16'h800C;

  localparam logic [31:0] DataDecodeErr  = 32'hDEAD_BEEF;
  localparam logic [31:0] DataTimeoutErr = 32'hDEAD_DEAD;

endpackage

// File: rtl/reram_bridge_csr.sv
// Bridge control/status registers: STATUS, CTRL, TIMEOUT, TXCNT and the
// registered error interrupt.
module reram_bridge_csr
  import reram_bridge_pkg::*;
#(
  parameter int unsigned NUM_MACROS  = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [15:0] off_i,
  input  logic [15:0] wdata_i,
  input  logic [1:0]  sel_i,
  input  logic        derr_set_i,
  input  logic        terr_set_i,
  input  logic [2:0]  err_idx_i,
  input  logic        tx_inc_i,
  input  logic        busy_i,
  output logic [31:0] rdata_o,
  output logic [7:0]  mask_o,
  output logic [15:0] timeout_o,
  output logic        irq_o
);

  logic                  terr_q, terr_d;
  logic                  derr_q, derr_d;
  logic [2:0]            err_idx_q, err_idx_d;
  logic [NUM_MACROS-1:0] mask_q, mask_d;
  logic                  irq_en_q, irq_en_d;
  logic [15:0]           timeout_q, timeout_d;
  logic [31:0]           txcnt_q, txcnt_d;
  logic                  irq_q, irq_d;
  logic [15:0]           to_merge;
  logic                  wr_status, wr_ctrl, wr_timeout;

  always_comb begin
    wr_status  = we_i && (off_i == CsrStatus);
    wr_ctrl    = we_i && (off_i == CsrCtrl);
    wr_timeout = we_i && (off_i == CsrTimeout);

    // Clear first so a same-cycle hardware set takes priority.
    terr_d = terr_q;
    derr_d = derr_q;
    if (wr_status && sel_i[0] && wdata_i[1]) terr_d = 1'b0;
    if (wr_status && sel_i[0] && wdata_i[2]) derr_d = 1'b0;
    if (terr_set_i) terr_d = 1'b1;
    if (derr_set_i) derr_d = 1'b1;
    err_idx_d = terr_set_i ? err_idx_i : err_idx_q;

    mask_d   = mask_q;
    irq_en_d = irq_en_q;
    if (wr_ctrl && sel_i[0]) mask_d = wdata_i[NUM_MACROS-1:0];
    if (wr_ctrl && sel_i[1]) irq_en_d = wdata_i[8];

    to_merge = timeout_q;
    if (sel_i[0]) to_merge[7:0] = wdata_i[7:0];
    if (sel_i[1]) to_merge[15:8] = wdata_i[15:8];
    timeout_d = (wr_timeout && (to_merge != 16'd0)) ? to_merge : timeout_q;

    txcnt_d = tx_inc_i ? txcnt_q + 32'd1 : txcnt_q;
    irq_d   = irq_en_q & (terr_q | derr_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      terr_q    <= 1'b0;
      derr_q    <= 1'b0;
      err_idx_q <= 3'd0;
      mask_q    <= '1;
      irq_en_q  <= 1'b0;
      timeout_q <= 16'(TIMEOUT_CYC);
      txcnt_q   <= 32'd0;
      irq_q     <= 1'b0;
    end else begin
      terr_q    <= terr_d;
      derr_q    <= derr_d;
      err_idx_q <= err_idx_d;
      mask_q    <= mask_d;
      irq_en_q  <= irq_en_d;
      timeout_q <= timeout_d;
      txcnt_q   <= txcnt_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    mask_o = 8'd0;
    for (int i = 0; i < NUM_MACROS; i++) mask_o[i] = mask_q[i];
    case (off_i)
      CsrStatus:  rdata_o = {25'd0, err_idx_q, 1'b0, derr_q, terr_q, busy_i};
      CsrCtrl:    rdata_o = {23'd0, irq_en_q, mask_o};
      CsrTimeout: rdata_o = {16'd0, timeout_q};
      CsrTxcnt:   rdata_o = txcnt_q;
      default:    rdata_o = 32'd0;
    endcase
  end

  assign timeout_o = timeout_q;
  assign irq_o     = irq_q;

endmodule

// File: rtl/reram_wb_bridge_mc.sv
// Wishbone classic slave fronting up to eight ReRAM macros plus a CSR block.
// One transaction in flight; macro accesses are bounded by a timeout counter.
module reram_wb_bridge_mc
  import reram_bridge_pkg::*;
#(
  parameter int unsigned NUM_MACROS  = 4,
  parameter logic [15:0] BASE_HI     = 16'h3000,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic [31:0]             wbs_dat_o,
  output logic                    wbs_ack_o,
  output logic [NUM_MACROS-1:0]   mac_en,
  output logic                    mac_r_wb,
  output logic [31:0]             mac_di,
  output logic [31:0]             mac_ad,
  output logic [3:0]              mac_sel,
  input  logic [32*NUM_MACROS-1:0] mac_do,
  input  logic [NUM_MACROS-1:0]   mac_ack,
  output logic                    irq_o
);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] rdata_q, rdata_d;
  logic        abort_q, abort_d;
  logic [15:0] timer_q, timer_d;
  logic        r_wb_q, r_wb_d;
  logic [31:0] di_q, di_d, ad_q, ad_d;
  logic [3:0]  sel_q, sel_d;

  logic        hit, idx_ok, sel_ack;
  logic [2:0]  req_idx;
  logic [31:0] sel_do, csr_rdata;
  logic [7:0]  ctrl_mask;
  logic [15:0] csr_timeout;
  logic        csr_we, derr_set, terr_set, tx_inc;

  assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:16] == BASE_HI);
  assign req_idx = wbs_adr_i[14:12];
  assign idx_ok  = (32'(req_idx) < NUM_MACROS) && ctrl_mask[req_idx];

  // Only the addressed macro's ack and data are observed.
  always_comb begin
    sel_ack = 1'b0;
    sel_do  = 32'd0;
    mac_en  = '0;
    for (int i = 0; i < NUM_MACROS; i++) begin
      if (idx_q == 3'(i)) begin
        sel_ack   = mac_ack[i];
        sel_do    = mac_do[32*i +: 32];
        mac_en[i] = (state_q == StIssue) || (state_q == StWait);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rdata_d  = rdata_q;
    abort_d  = abort_q;
    timer_d  = timer_q;
    r_wb_d   = r_wb_q;
    di_d     = di_q;
    ad_d     = ad_q;
    sel_d    = sel_q;
    csr_we   = 1'b0;
    derr_set = 1'b0;
    terr_set = 1'b0;
    tx_inc   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (hit) begin
          abort_d = 1'b0;
          if (wbs_adr_i[15]) begin
            csr_we  = wbs_we_i;
            rdata_d = csr_rdata;
            state_d = StResp;
          end else if (!idx_ok) begin
            derr_set = 1'b1;
            rdata_d  = DataDecodeErr;
            state_d  = StResp;
          end else begin
            idx_d   = req_idx;
            r_wb_d  = ~wbs_we_i;
            di_d    = wbs_dat_i;
            ad_d    = {20'd0, wbs_adr_i[11:0]};
            sel_d   = wbs_sel_i;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        timer_d = csr_timeout;
        abort_d = abort_q | ~wbs_cyc_i;
        state_d = StWait;
      end
      StWait: begin
        // A dropped cycle still lets the macro finish, but skips the response.
        abort_d = abort_q | ~wbs_cyc_i;
        if (sel_ack) begin
          rdata_d = sel_do;
          tx_inc  = ~abort_d;
          state_d = abort_d ? StIdle : StResp;
        end else if (timer_q <= 16'd1) begin
          terr_set = 1'b1;
          rdata_d  = DataTimeoutErr;
          state_d  = abort_d ? StIdle : StResp;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      rdata_q <= 32'd0;
      abort_q <= 1'b0;
      timer_q <= 16'd0;
      r_wb_q  <= 1'b1;
      di_q    <= 32'd0;
      ad_q    <= 32'd0;
      sel_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      abort_q <= abort_d;
      timer_q <= timer_d;
      r_wb_q  <= r_wb_d;
      di_q    <= di_d;
      ad_q    <= ad_d;
      sel_q   <= sel_d;
    end
  end

  assign wbs_ack_o = (state_q == StResp);
  assign wbs_dat_o = wbs_ack_o ? rdata_q : 32'd0;
  assign mac_r_wb  = r_wb_q;
  assign mac_di    = di_q;
  assign mac_ad    = ad_q;
  assign mac_sel   = sel_q;

  reram_bridge_csr #(
    .NUM_MACROS  (NUM_MACROS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_csr (
    .clk_i      (wb_clk_i),
    .rst_ni     (wb_rst_i),
    .we_i       (csr_we),
    .off_i      (wbs_adr_i[15:0]),
    .wdata_i    (wbs_dat_i[15:0]),
    .sel_i      (wbs_sel_i[1:0]),
    .derr_set_i (derr_set),
    .terr_set_i (terr_set),
    .err_idx_i  (idx_q),
    .tx_inc_i   (tx_inc),
    .busy_i     (state_q != StIdle),
    .rdata_o    (csr_rdata),
    .mask_o     (ctrl_mask),
    .timeout_o  (csr_timeout),
    .irq_o      (irq_o)
  );

endmodule

// File: doc/reram_wb_bridge_mc.md
RERAM_WB_BRIDGE_MC -- requirements
Module: reram_wb_bridge_mc

Interface
REQ-001 Parameter NUM_MACROS, default 4, number of attached ReRAM macros (legal 1..8).
REQ-002 Parameter BASE_HI, default 16'h3000, match value for wbs_adr_i[31:16].
REQ-003 Parameter TIMEOUT_CYC, default 1024, reset value of the timeout register (16 bits, non-zero).
REQ-004 wb_clk_i  in  1  sole clock; all logic rises on this edge.
REQ-005 wb_rst_i  in  1  reset, asynchronous assert, active-low.
REQ-006 wbs_cyc_i, wbs_stb_i  in  1 each  Wishbone classic cycle/strobe.
REQ-007 wbs_we_i  in  1  1=write, 0=read.
REQ-008 wbs_sel_i  in  4  byte select; wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data.
REQ-009 wbs_dat_o  out  32  read data; wbs_ack_o  out  1  single-cycle acknowledge.
REQ-010 mac_en  out  NUM_MACROS  one-hot macro enable; mac_r_wb  out  1  1=read, 0=write; mac_di  out  32; mac_ad  out  32; mac_sel  out  4 (shared across macros).
REQ-011 mac_do  in  32*NUM_MACROS  per-macro read data; mac_ack  in  NUM_MACROS  per-macro func_ack.
REQ-012 irq_o  out  1  level interrupt.

Function
REQ-013 Hit: cyc&stb&(wbs_adr_i[31:16]==BASE_HI); non-hits are ignored, never acked.
REQ-014 adr[15]=1 selects CSR space; adr[15]=0 selects macro space, index=adr[14:12], mac_ad={20'b0,adr[11:0]}.
REQ-015 FSM states IDLE, ISSUE, WAIT, RESP; only IDLE accepts a request.
REQ-016 CSR access: IDLE->RESP; ack asserted the cycle after the request is sampled (latency 1).
REQ-017 Macro index >= NUM_MACROS or disabled in CTRL mask: IDLE->RESP, ack latency 1, read data 32'hDEAD_BEEF, write discarded, STATUS.derr set.
REQ-018 Valid macro request: IDLE->ISSUE registers r_wb=~we, di, ad, sel; ISSUE drives mac_en[index]=1 and loads the timeout counter.
REQ-019 mac_en and mac_di/ad/sel/r_wb stay stable through ISSUE and WAIT until mac_ack[index] is sampled high or timeout occurs.
REQ-020 WAIT->RESP on mac_ack[index]; read data captured from mac_do[index] that cycle; mac_en drops in RESP.
REQ-021 Timeout counter decrements each WAIT cycle; at zero -> RESP, read data 32'hDEAD_DEAD, STATUS.terr set, STATUS.err_idx=index.
REQ-022 RESP: wbs_ack_o=1 for exactly one cycle with wbs_dat_o valid; next state IDLE; wbs_dat_o=0 when ack low.
REQ-023 cyc dropped during ISSUE/WAIT: transaction completes to the macro (ack or timeout) but no wbs_ack_o issued; return to IDLE.
REQ-024 mac_ack from a non-selected macro is ignored.
REQ-025 CSR 0x8000 STATUS: [0] busy (state!=IDLE), [1] terr, [2] derr, [6:4] err_idx; write 1 to [1]/[2] clears; set wins over simultaneous clear.
REQ-026 CSR 0x8004 CTRL: [7:0] enable mask, [8] irq_en; bits >= NUM_MACROS read 0.
REQ-027 CSR 0x8008 TIMEOUT: [15:0] RW; write of 0 ignored.
REQ-028 CSR 0x800C TXCNT: RO, +1 per macro transaction reaching RESP via mac_ack, wraps 32'hFFFF_FFFF->0.
REQ-029 Unmapped CSR offsets read 0, writes ignored, acked normally.
REQ-030 CSR writes honour wbs_sel_i per byte.
REQ-031 irq_o = irq_en & (terr|derr), registered.

Reset
REQ-032 On wb_rst_i low: state IDLE, wbs_ack_o=0, wbs_dat_o=0, mac_en=0, mac_di/ad=0, mac_sel=0, mac_r_wb=1, irq_o=0.
REQ-033 Reset values: STATUS=0, CTRL mask=all NUM_MACROS bits 1, irq_en=0, TIMEOUT=TIMEOUT_CYC, TXCNT=0.
REQ-034 Reset mid-transaction deasserts mac_en immediately; no ack is generated for the aborted cycle.

Structure
REQ-035 Shared package reram_bridge_pkg holds the FSM state enum, CSR offsets, and the 32'hDEAD_BEEF/32'hDEAD_DEAD error constants.
REQ-036 One sub-module, reram_bridge_csr, holds STATUS/CTRL/TIMEOUT/TXCNT and irq_o; FSM and datapath stay in the top.

Verification
REQ-037 Write 0x1234_5678 to 0x3000_1010, macro 1 acks after 5 cycles -> mac_en=4'b0010 for 6 cycles, mac_ad=0x010, mac_r_wb=0, one wbs_ack_o, TXCNT=1.
REQ-038 Read 0x3000_2004, macro 2 returns 0xA5A5_0F0F with ack after 3 cycles -> wbs_dat_o=0xA5A5_0F0F on the ack cycle only.
REQ-039 TIMEOUT=8, read macro 0 with no ack -> ack after 10 cycles, data 0xDEAD_DEAD, STATUS=0x0000_0002, irq_o=1 once irq_en set; write 0x2 to STATUS clears it.
REQ-040 Access 0x3000_5000 with NUM_MACROS=4 -> ack next cycle, data 0xDEAD_BEEF, STATUS.derr=1, no mac_en pulse.
REQ-041 Assert reset during WAIT -> mac_en=0 asynchronously, no ack; a post-reset CTRL read returns 0x0000_000F.
REQ-042 Access 0x4000_0000 -> no ack, no mac_en, FSM stays IDLE.
